// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared FSM states, RV32I load/store funct3 codes and beat helpers
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MA_IDLE  = 2'd0,
        MA_ISSUE = 2'd1,
        MA_DRAIN = 2'd2,
        MA_RESP  = 2'd3
    } ma_state_t;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    function automatic logic [2:0] beats_for(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [1:0] last_beat_for(input logic [1:0] size);
        case (size)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_load_ext.sv
// rtl/mem_arbiter_load_ext.sv - merges a returning read byte into its lane and extends the result
module mem_load_ext
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] i_raw,
    input  logic [7:0]  i_byte,
    input  logic [1:0]  i_lane,
    input  logic        i_lane_vld,
    input  logic [2:0]  i_beats,
    input  logic        i_unsigned,
    output logic [31:0] o_raw,
    output logic [31:0] o_data
);

    always_comb begin
        o_raw  = i_raw;
        o_data = 32'h0;
        if (i_lane_vld) begin
            o_raw[{i_lane, 3'b000} +: 8] = i_byte;
        end
        // Lanes above 8N-1 may hold stale bytes from an earlier access; extension masks them.
        case (i_beats)
            3'd1:    o_data = {{24{~i_unsigned & o_raw[7]}}, o_raw[7:0]};
            3'd2:    o_data = {{16{~i_unsigned & o_raw[15]}}, o_raw[15:0]};
            default: o_data = o_raw;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial RAM port arbiter for fetch and load/store; MEM_ARB_MISALIGN_CHK_EN enables misalignment traps
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_err,
    output logic        stallreq_if,
    output logic        stallreq_mem,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    ma_state_t          r_state;
    ma_state_t          w_state_nxt;
    logic               r_gnt_if;
    logic               r_we;
    logic               r_uns;
    logic [31:0]        r_base;
    logic [31:0]        r_wdata;
    logic [31:0]        r_raw;
    logic [2:0]         r_beats;
    logic [1:0]         r_klast;
    logic [1:0]         r_k;
    logic [MEM_LAT-1:0] r_vld;
    logic [1:0]         r_idx [MEM_LAT];
    logic [31:0]        r_if_rdata;
    logic [31:0]        r_d_rdata;
    logic               r_d_err;

    logic               w_issue;
    logic               w_cap_vld;
    logic [1:0]         w_cap_idx;
    logic               w_cap_last;
    logic               w_misalign;
    logic               w_enter_resp;
    logic [31:0]        w_raw_nxt;
    logic [31:0]        w_ext;

`ifdef MEM_ARB_MISALIGN_CHK_EN
    assign w_misalign = is_misaligned(d_funct3[1:0], d_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_issue    = (r_state == MA_ISSUE);
    assign w_cap_vld  = r_vld[MEM_LAT-1];
    assign w_cap_idx  = r_idx[MEM_LAT-1];
    assign w_cap_last = w_cap_vld && (w_cap_idx == r_klast);

    mem_load_ext u_load_ext (
        .i_raw      (r_raw),
        .i_byte     (ram_rdata),
        .i_lane     (w_cap_idx),
        .i_lane_vld (w_cap_vld),
        .i_beats    (r_beats),
        .i_unsigned (r_uns),
        .o_raw      (w_raw_nxt),
        .o_data     (w_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= MA_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MA_IDLE: begin
                if (d_req) begin
                    w_state_nxt = w_misalign ? MA_RESP : MA_ISSUE;
                end else if (if_req) begin
                    w_state_nxt = MA_ISSUE;
                end
            end
            MA_ISSUE: begin
                if (r_k == r_klast) begin
                    w_state_nxt = r_we ? MA_RESP : MA_DRAIN;
                end
            end
            MA_DRAIN: begin
                if (w_cap_last) begin
                    w_state_nxt = MA_RESP;
                end
            end
            default: w_state_nxt = MA_IDLE;
        endcase
    end

    assign w_enter_resp = (w_state_nxt == MA_RESP) && (r_state != MA_RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt_if   <= 1'b0;
            r_we       <= 1'b0;
            r_uns      <= 1'b0;
            r_base     <= 32'h0;
            r_wdata    <= 32'h0;
            r_raw      <= 32'h0;
            r_beats    <= 3'd0;
            r_klast    <= 2'd0;
            r_k        <= 2'd0;
            r_vld      <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                r_idx[i] <= 2'd0;
            end
            r_if_rdata <= 32'h0;
            r_d_rdata  <= 32'h0;
            r_d_err    <= 1'b0;
        end else begin
            r_raw    <= w_raw_nxt;
            r_vld[0] <= w_issue && !r_we;
            r_idx[0] <= r_k;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_idx[i] <= r_idx[i-1];
            end

            if (r_state == MA_IDLE) begin
                r_k <= 2'd0;
                // Data wins a tie: the older instruction in the pipeline is the one in LOAD/STORE.
                if (d_req) begin
                    r_gnt_if <= 1'b0;
                    r_we     <= d_we;
                    r_uns    <= d_funct3[2];
                    r_base   <= d_addr;
                    r_wdata  <= d_wdata;
                    r_beats  <= beats_for(d_funct3[1:0]);
                    r_klast  <= last_beat_for(d_funct3[1:0]);
                end else if (if_req) begin
                    r_gnt_if <= 1'b1;
                    r_we     <= 1'b0;
                    r_uns    <= 1'b1;
                    r_base   <= if_addr;
                    r_beats  <= 3'd4;
                    r_klast  <= 2'd3;
                end
            end else if (w_issue) begin
                r_k <= r_k + 2'd1;
            end

            if (w_enter_resp) begin
                if (r_state == MA_IDLE) begin
                    r_d_rdata <= 32'h0;
                    r_d_err   <= 1'b1;
                end else if (r_gnt_if) begin
                    r_if_rdata <= w_ext;
                end else begin
                    r_d_rdata <= r_we ? 32'h0 : w_ext;
                    r_d_err   <= 1'b0;
                end
            end
        end
    end

    assign if_done      = (r_state == MA_RESP) && r_gnt_if;
    assign d_done       = (r_state == MA_RESP) && !r_gnt_if;
    assign if_rdata     = r_if_rdata;
    assign d_rdata      = r_d_rdata;
    assign d_err        = r_d_err;
    assign stallreq_if  = if_req && !if_done;
    assign stallreq_mem = d_req && !d_done;

    assign ram_addr  = w_issue ? (r_base + {30'd0, r_k}) : 32'h0;
    assign ram_we    = w_issue && r_we;
    assign ram_wdata = (w_issue && r_we) ? r_wdata[{r_k, 3'b000} +: 8] : 8'h0;

endmodule
